// File: rtl/usb_in_ep_arbiter_pkg.sv
// Shared definitions for the USB IN endpoint arbiter: FSM encoding and
// the fixed endpoint index of each IN source.
package usb_in_ep_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int EP_IDX_CTRL       = 0;
  localparam int EP_IDX_CDC_TX     = 1;
  localparam int EP_IDX_CDC_NOTIFY = 2;

endpackage

// File: rtl/usb_in_ep_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after rr_ptr,
// searching upward modulo NUM_EP. Shared with the OUT-side arbiter.
module rr_priority_picker
  import usb_in_ep_arbiter_pkg::*;
#(
  parameter int NUM_EP = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_EP-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              valid
);

  localparam logic [IDX_W:0] NUM_EP_W = (IDX_W+1)'(NUM_EP);

  logic [IDX_W:0]   raw_s;
  logic [IDX_W-1:0] idx_s;

  // Scan from the farthest slot down so the closest requester is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    raw_s  = '0;
    idx_s  = '0;
    for (int k = NUM_EP - 1; k >= 0; k--) begin
      raw_s  = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      raw_s  = (raw_s >= NUM_EP_W) ? (raw_s - NUM_EP_W) : raw_s;
      idx_s  = raw_s[IDX_W-1:0];
      winner = req[idx_s] ? idx_s : winner;
      valid  = req[idx_s] | valid;
    end
  end

endmodule

// File: rtl/usb_in_ep_arbiter.sv
// Round-robin arbiter sharing the USB IN packet buffer port between IN
// endpoint sources; grants are held for a whole packet.
module usb_in_ep_arbiter
  import usb_in_ep_arbiter_pkg::*;
#(
  parameter int NUM_EP = 3,
  parameter int IDX_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EP-1:0]     ep_req,
  output logic [NUM_EP-1:0]     ep_grant,
  input  logic [NUM_EP-1:0]     ep_data_put,
  input  logic [8*NUM_EP-1:0]   ep_data,
  input  logic [NUM_EP-1:0]     ep_data_done,
  input  logic [NUM_EP-1:0]     ep_stall,
  output logic                  buf_data_put,
  output logic [7:0]            buf_data,
  output logic                  buf_data_done,
  output logic                  buf_stall,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy,
  output logic                  proto_err
);

  arb_state_t        state_r;
  logic [NUM_EP-1:0] grant_r;
  logic [IDX_W-1:0]  owner_r;
  logic [IDX_W-1:0]  rr_ptr_r;
  logic              busy_r;
  logic              proto_err_r;

  logic [IDX_W-1:0]  pick_s;
  logic              pick_valid_s;
  logic              release_s;
  logic [IDX_W-1:0]  rr_next_s;
  logic [NUM_EP-1:0] owner_onehot_s;
  logic [NUM_EP-1:0] activity_s;
  logic              violation_s;

  rr_priority_picker #(
    .NUM_EP (NUM_EP),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req    (ep_req),
    .rr_ptr (rr_ptr_r),
    .winner (pick_s),
    .valid  (pick_valid_s)
  );

  assign release_s      = ep_data_done[owner_r] | ep_stall[owner_r] | ~ep_req[owner_r];
  assign rr_next_s      = (owner_r == IDX_W'(NUM_EP - 1)) ? '0 : (owner_r + IDX_W'(1));
  assign owner_onehot_s = NUM_EP'(1) << owner_r;
  assign activity_s     = ep_data_put | ep_data_done | ep_stall;
  // Outside a grant nobody may legally drive the port, but pre-grant puts are simply dropped.
  assign violation_s    = busy_r & (|(activity_s & ~owner_onehot_s));

  // Arbitration FSM: grant, hold for one packet, one dead release cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ARB_IDLE;
      grant_r  <= '0;
      owner_r  <= '0;
      rr_ptr_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_valid_s) begin
            state_r <= ARB_GRANT;
            grant_r <= NUM_EP'(1) << pick_s;
            owner_r <= pick_s;
            busy_r  <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (release_s) begin
            state_r  <= ARB_RELEASE;
            grant_r  <= '0;
            busy_r   <= 1'b0;
            rr_ptr_r <= rr_next_s;
          end
        end
        ARB_RELEASE: begin
          state_r <= ARB_IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ARB_IDLE;
          grant_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      proto_err_r <= 1'b0;
    end else if (violation_s) begin
      proto_err_r <= 1'b1;
    end
  end

  // Zero-latency mux of the owner's handshake onto the buffer port.
  always_comb begin
    buf_data_put  = 1'b0;
    buf_data      = 8'h00;
    buf_data_done = 1'b0;
    buf_stall     = 1'b0;
    if (busy_r) begin
      buf_data_put  = ep_data_put[owner_r];
      buf_data      = ep_data[{owner_r, 3'b000} +: 8];
      buf_data_done = ep_data_done[owner_r];
      buf_stall     = ep_stall[owner_r];
    end else begin
      buf_data_put  = 1'b0;
      buf_data      = 8'h00;
      buf_data_done = 1'b0;
      buf_stall     = 1'b0;
    end
  end

  assign ep_grant  = grant_r;
  assign owner     = owner_r;
  assign busy      = busy_r;
  assign proto_err = proto_err_r;

endmodule

// File: tb/tb_usb_in_ep_arbiter.sv
// Directed self-checking bench for usb_in_ep_arbiter (NUM_EP=3).
module tb_usb_in_ep_arbiter;

  logic        clk;
  logic        reset_n;
  logic [2:0]  ep_req;
  logic [2:0]  ep_grant;
  logic [2:0]  ep_data_put;
  logic [23:0] ep_data;
  logic [2:0]  ep_data_done;
  logic [2:0]  ep_stall;
  logic        buf_data_put;
  logic [7:0]  buf_data;
  logic        buf_data_done;
  logic        buf_stall;
  logic [1:0]  owner;
  logic        busy;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  usb_in_ep_arbiter #(.NUM_EP(3), .IDX_W(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ep_req        (ep_req),
    .ep_grant      (ep_grant),
    .ep_data_put   (ep_data_put),
    .ep_data       (ep_data),
    .ep_data_done  (ep_data_done),
    .ep_stall      (ep_stall),
    .buf_data_put  (buf_data_put),
    .buf_data      (buf_data),
    .buf_data_done (buf_data_done),
    .buf_stall     (buf_stall),
    .owner         (owner),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Wait for a grant, check order and gap, then close the packet with done.
  task automatic run_packet(input int exp_owner, input int exp_wait);
    int cnt;
    cnt = 0;
    while (ep_grant == 3'b000 && cnt < 8) begin
      nxt();
      cnt++;
    end
    chk("pkt_wait", cnt, exp_wait);
    chk("pkt_grant", {29'd0, ep_grant}, 32'd1 << exp_owner);
    chk("pkt_owner", {30'd0, owner}, exp_owner);
    ep_data_done[exp_owner] = 1'b1;
    #1;
    chk("pkt_done_pass", {31'd0, buf_data_done}, 32'd1);
    nxt();
    ep_data_done = 3'b000;
    chk("pkt_release_grant", {29'd0, ep_grant}, 32'd0);
    chk("pkt_release_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    ep_req       = 3'b000;
    ep_data_put  = 3'b000;
    ep_data      = 24'h000000;
    ep_data_done = 3'b000;
    ep_stall     = 3'b000;
    #3;
    chk("rst_grant", {29'd0, ep_grant}, 32'd0);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_proto", {31'd0, proto_err}, 32'd0);
    chk("rst_buf_put", {31'd0, buf_data_put}, 32'd0);

    // Single requester, three bytes then done
    @(negedge clk);
    reset_n = 1'b1;
    ep_req  = 3'b010;
    #1;
    chk("t1_no_grant_yet", {29'd0, ep_grant}, 32'd0);
    nxt();
    chk("t1_grant", {29'd0, ep_grant}, 32'd2);
    chk("t1_owner", {30'd0, owner}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    ep_data_put   = 3'b010;
    ep_data[15:8] = 8'h11;
    #1;
    chk("t1_put0", {31'd0, buf_data_put}, 32'd1);
    chk("t1_byte0", {24'd0, buf_data}, 32'h11);
    nxt();
    ep_data[15:8] = 8'h22;
    #1;
    chk("t1_byte1", {24'd0, buf_data}, 32'h22);
    nxt();
    ep_data[15:8] = 8'h33;
    #1;
    chk("t1_byte2", {24'd0, buf_data}, 32'h33);
    nxt();
    ep_data_put  = 3'b000;
    ep_data_done = 3'b010;
    #1;
    chk("t1_done", {31'd0, buf_data_done}, 32'd1);
    chk("t1_grant_hold", {29'd0, ep_grant}, 32'd2);
    nxt();
    ep_data_done = 3'b000;
    ep_req       = 3'b000;
    chk("t1_rel_grant", {29'd0, ep_grant}, 32'd0);
    chk("t1_rel_busy", {31'd0, busy}, 32'd0);
    chk("t1_rel_buf_put", {31'd0, buf_data_put}, 32'd0);

    // Simultaneous requests from reset: order 0,1,2,0
    reset_n = 1'b0;
    nxt();
    reset_n = 1'b1;
    ep_req  = 3'b111;
    run_packet(0, 1);
    run_packet(1, 2);
    run_packet(2, 2);
    run_packet(0, 2);

    // Only sources 2 and 0: alternation with pointer wrap
    ep_req = 3'b101;
    run_packet(2, 2);
    run_packet(0, 2);
    run_packet(2, 2);
    run_packet(0, 2);

    // Early release by dropping the request
    ep_req = 3'b010;
    nxt();
    nxt();
    chk("t4_grant", {29'd0, ep_grant}, 32'd2);
    ep_data_put   = 3'b010;
    ep_data[15:8] = 8'h44;
    #1;
    chk("t4_byte", {24'd0, buf_data}, 32'h44);
    nxt();
    ep_data_put = 3'b000;
    ep_req      = 3'b000;
    chk("t4_still_granted", {29'd0, ep_grant}, 32'd2);
    chk("t4_no_done_a", {31'd0, buf_data_done}, 32'd0);
    nxt();
    chk("t4_dropped", {29'd0, ep_grant}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_no_done_b", {31'd0, buf_data_done}, 32'd0);
    chk("t4_proto", {31'd0, proto_err}, 32'd0);

    // Violation by source 2 during owner 0
    ep_req = 3'b001;
    nxt();
    nxt();
    chk("t5_grant", {29'd0, ep_grant}, 32'd1);
    ep_data_put    = 3'b100;
    ep_data[23:16] = 8'hAA;
    ep_data[7:0]   = 8'h5A;
    #1;
    chk("t5_put_blocked", {31'd0, buf_data_put}, 32'd0);
    chk("t5_data_owner", {24'd0, buf_data}, 32'h5A);
    chk("t5_proto_pre", {31'd0, proto_err}, 32'd0);
    nxt();
    ep_data_put = 3'b001;
    chk("t5_proto_set", {31'd0, proto_err}, 32'd1);
    #1;
    chk("t5_owner_put", {31'd0, buf_data_put}, 32'd1);
    nxt();
    ep_data_put  = 3'b000;
    ep_data_done = 3'b001;
    nxt();
    ep_data_done = 3'b000;
    ep_req       = 3'b000;
    chk("t5_rel_grant", {29'd0, ep_grant}, 32'd0);
    nxt();
    nxt();
    chk("t5_proto_sticky", {31'd0, proto_err}, 32'd1);

    // Asynchronous reset in the middle of a packet from source 1
    ep_req = 3'b010;
    nxt();
    chk("t6_grant", {29'd0, ep_grant}, 32'd2);
    ep_data_put   = 3'b010;
    ep_data[15:8] = 8'h77;
    #1;
    chk("t6_put", {31'd0, buf_data_put}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_async_grant", {29'd0, ep_grant}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_put", {31'd0, buf_data_put}, 32'd0);
    chk("t6_async_proto", {31'd0, proto_err}, 32'd0);
    chk("t6_async_owner", {30'd0, owner}, 32'd0);
    nxt();
    chk("t6_held_grant", {29'd0, ep_grant}, 32'd0);
    ep_data_put = 3'b000;
    ep_req      = 3'b110;
    reset_n     = 1'b1;
    nxt();
    chk("t6_first_grant", {29'd0, ep_grant}, 32'd2);
    chk("t6_first_owner", {30'd0, owner}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
